// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: FSM states, the Decoder
// instruction-set fields it emits, and a word-packing helper.
package mult_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOADA,
        S_LOADB,
        S_CLR,
        S_COPY,
        S_MASK,
        S_TEST,
        S_CHK,
        S_SHL,
        S_SHR,
        S_READ,
        S_DONE
    } state_t;

    // Decoder opcodes (bits 15:12)
    localparam logic [3:0] OP_REGISTER = 4'b0000;
    localparam logic [3:0] OP_ANDI     = 4'b0001;
    localparam logic [3:0] OP_SHIFT    = 4'b1000;
    localparam logic [3:0] OP_MOVI     = 4'b1101;

    // Register/shift extension codes (bits 7:4)
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_MOV = 4'b1101;
    localparam logic [3:0] EXT_LSH = 4'b0100;

    // Signed 4-bit shift amounts carried in bits 3:0 of an LSH word
    localparam logic [3:0] SHIFT_LEFT_1  = 4'b0001;
    localparam logic [3:0] SHIFT_RIGHT_1 = 4'b1111;

    // Position of the zero flag within the Decoder flag vector
    localparam int FLAG_Z = 4;

    function automatic logic [15:0] make_word(
        input logic [3:0] op,
        input logic [3:0] rdst,
        input logic [3:0] hi,
        input logic [3:0] lo
    );
        return {op, rdst, hi, lo};
    endfunction

endpackage

// File: rtl/mult_instr_rom.sv
// Pure combinational map from sequencer state (plus Z in CHK and the latched
// operands in the load states) to the instruction word handed to Decoder.
module mult_instr_rom
    import mult_sequencer_pkg::*;
#(
    parameter int RA = 0,
    parameter int RB = 1,
    parameter int RT = 2,
    parameter int RP = 3
) (
    input  state_t      state,
    input  logic        z,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] instruction
);

    localparam logic [3:0] RA_ID = 4'(RA);
    localparam logic [3:0] RB_ID = 4'(RB);
    localparam logic [3:0] RT_ID = 4'(RT);
    localparam logic [3:0] RP_ID = 4'(RP);

    // Select the word for the current state; MOV RP,RP is the idle filler
    always_comb begin
        instruction = make_word(OP_REGISTER, RP_ID, EXT_MOV, RP_ID);
        case (state)
            S_LOADA: instruction = {OP_MOVI, RA_ID, a};
            S_LOADB: instruction = {OP_MOVI, RB_ID, b};
            S_CLR:   instruction = {OP_MOVI, RP_ID, 8'h00};
            S_COPY:  instruction = make_word(OP_REGISTER, RT_ID, EXT_MOV, RB_ID);
            S_MASK:  instruction = {OP_ANDI, RT_ID, 8'h01};
            S_TEST:  instruction = make_word(OP_REGISTER, RT_ID, EXT_MOV, RT_ID);
            // LSB clear: fold the multiplicand shift into this cycle
            S_CHK:   instruction = z ? make_word(OP_SHIFT, RA_ID, EXT_LSH, SHIFT_LEFT_1)
                                     : make_word(OP_REGISTER, RP_ID, EXT_ADD, RA_ID);
            S_SHL:   instruction = make_word(OP_SHIFT, RA_ID, EXT_LSH, SHIFT_LEFT_1);
            S_SHR:   instruction = make_word(OP_SHIFT, RB_ID, EXT_LSH, SHIFT_RIGHT_1);
            default: instruction = make_word(OP_REGISTER, RP_ID, EXT_MOV, RP_ID);
        endcase
    end

endmodule

// File: rtl/mult_sequencer.sv
// Shift-and-add multiply sequencer: drives Decoder one instruction per clock,
// branches on Decoder's Z flag, and captures the product from ALUBus.
//
// state | meaning
// IDLE  | waiting for Start; presents MOV RP,RP
// LOADA | MOVI RA,A
// LOADB | MOVI RB,B
// CLR   | MOVI RP,0
// COPY  | MOV RT,RB
// MASK  | ANDI RT,1
// TEST  | MOV RT,RT to set Z from the multiplier LSB
// CHK   | Z=0: ADD RP,RA; Z=1: LSH RA,+1 and skip SHL
// SHL   | LSH RA,+1
// SHR   | LSH RB,-1; counts iterations
// READ  | MOV RP,RP; product captured from ALUBus on exit
// DONE  | Done pulse
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RA    = 0,
    parameter int RB    = 1,
    parameter int RT    = 2,
    parameter int RP    = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Flags,
    input  logic [15:0]      ALUBus,
    output logic [15:0]      Instruction,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Product
);

    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       count;
    logic [7:0]       a_ext;
    logic [7:0]       b_ext;
    logic             unused_flags;

    assign a_ext        = 8'(a_q);
    assign b_ext        = 8'(b_q);
    assign unused_flags = ^Flags[3:0];

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand latch, iteration counter and product capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            count   <= '0;
            Product <= '0;
        end else begin
            if (state == S_IDLE && Start) begin
                a_q   <= A;
                b_q   <= B;
                count <= '0;
            end
            if (state == S_SHR) begin
                count <= count + 4'd1;
            end
            if (state == S_READ) begin
                Product <= ALUBus;
            end
        end
    end

    // Next-state and status outputs
    always_comb begin
        next_state = state;
        Busy       = 1'b1;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) next_state = S_LOADA;
            end
            S_LOADA: next_state = S_LOADB;
            S_LOADB: next_state = S_CLR;
            S_CLR:   next_state = S_COPY;
            S_COPY:  next_state = S_MASK;
            S_MASK:  next_state = S_TEST;
            S_TEST:  next_state = S_CHK;
            S_CHK:   next_state = Flags[FLAG_Z] ? S_SHR : S_SHL;
            S_SHL:   next_state = S_SHR;
            S_SHR:   next_state = (count == LAST_ITER) ? S_READ : S_COPY;
            S_READ:  next_state = S_DONE;
            S_DONE: begin
                Busy       = 1'b0;
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                Busy       = 1'b0;
                next_state = S_IDLE;
            end
        endcase
    end

    mult_instr_rom #(
        .RA(RA),
        .RB(RB),
        .RT(RT),
        .RP(RP)
    ) u_rom (
        .state       (state),
        .z           (Flags[FLAG_Z]),
        .a           (a_ext),
        .b           (b_ext),
        .instruction (Instruction)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer driving a small behavioural Decoder model.
module tb_mult_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [4:0]  Flags;
    logic [15:0] ALUBus;
    logic [15:0] Instruction;
    logic        Busy;
    logic        Done;
    logic [15:0] Product;

    int checks = 0;
    int errors = 0;

    // Hand-coded Decoder ISA as seen by this bench
    localparam logic [15:0] W_IDLE = 16'h03D3; // MOV RP,RP

    mult_sequencer #(.WIDTH(8), .RA(0), .RB(1), .RT(2), .RP(3)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .A           (A),
        .B           (B),
        .Flags       (Flags),
        .ALUBus      (ALUBus),
        .Instruction (Instruction),
        .Busy        (Busy),
        .Done        (Done),
        .Product     (Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // ---------------- Decoder model ----------------
    logic [15:0] regs [16];
    logic        z_flag;
    logic [15:0] alu_res;
    logic        alu_wr;
    logic [3:0]  f_op, f_rd, f_ext, f_lo;

    assign f_op  = Instruction[15:12];
    assign f_rd  = Instruction[11:8];
    assign f_ext = Instruction[7:4];
    assign f_lo  = Instruction[3:0];

    always_comb begin
        alu_res = 16'h0000;
        alu_wr  = 1'b0;
        case (f_op)
            4'hD: begin alu_res = {8'h00, Instruction[7:0]}; alu_wr = 1'b1; end
            4'h1: begin alu_res = regs[f_rd] & {8'h00, Instruction[7:0]}; alu_wr = 1'b1; end
            4'h0: begin
                if (f_ext == 4'hD) begin alu_res = regs[f_lo]; alu_wr = 1'b1; end
                else if (f_ext == 4'h5) begin alu_res = regs[f_rd] + regs[f_lo]; alu_wr = 1'b1; end
            end
            4'h8: begin
                if (f_ext == 4'h4) begin
                    if (f_lo[3]) alu_res = regs[f_rd] >> (5'd16 - {1'b0, f_lo});
                    else         alu_res = regs[f_rd] << f_lo;
                    alu_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            z_flag <= 1'b0;
        end else if (alu_wr) begin
            regs[f_rd] <= alu_res;
            z_flag     <= (alu_res == 16'h0000);
        end
    end

    assign ALUBus = alu_res;
    assign Flags  = {z_flag, 4'b0000};

    // ---------------- helpers ----------------
    logic [15:0] words [8];
    int          r_busy, r_done, r_add;
    logic [15:0] r_prod;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: pulse Start for one cycle, then observe 70 cycles.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
        A = a; B = b; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        r_busy = 0; r_done = 0; r_add = 0; r_prod = 16'hxxxx;
        for (int c = 0; c < 70; c++) begin
            if (c < 8) words[c] = Instruction;
            if (Busy) r_busy++;
            if (Instruction[15:12] == 4'h0 && Instruction[7:4] == 4'h5) r_add++;
            if (Done) begin r_done++; r_prod = Product; end
            @(negedge Clock);
        end
    endtask

    int done_n, rises, busy_n;
    logic prev_busy;
    logic [15:0] prod2;

    initial begin
        Reset = 1'b1; Start = 1'b0; A = 8'h00; B = 8'h00;
        #12;
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_product", 32'(Product), 32'd0);
        check("reset_instr", 32'(Instruction), 32'(W_IDLE));
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        // Test 1 plus instruction monitor
        run_mult(8'h1F, 8'hE3);
        check("t1_product", 32'(r_prod), 32'h1B7D);
        check("t1_busy", 32'(r_busy), 32'd49);
        check("t1_done", 32'(r_done), 32'd1);
        check("t1_w0_movi_ra", 32'(words[0]), 32'hD01F);
        check("t1_w1_movi_rb", 32'(words[1]), 32'hD1E3);
        check("t1_w2_movi_rp", 32'(words[2]), 32'hD300);
        check("t1_w3_mov_rt_rb", 32'(words[3]), 32'h02D1);
        check("t1_w4_andi_rt", 32'(words[4]), 32'h1201);
        check("t1_w5_mov_rt_rt", 32'(words[5]), 32'h02D2);
        check("t1_w6_add_rp_ra", 32'(words[6]), 32'h0350);
        check("t1_w7_lsh_ra", 32'(words[7]), 32'h8041);
        check("t1_prod_hold", 32'(Product), 32'h1B7D);

        // Test 2
        run_mult(8'hFF, 8'hFF);
        check("t2a_product", 32'(r_prod), 32'hFE01);
        check("t2a_busy", 32'(r_busy), 32'd52);
        check("t2a_done", 32'(r_done), 32'd1);
        run_mult(8'h01, 8'h01);
        check("t2b_product", 32'(r_prod), 32'h0001);
        check("t2b_busy", 32'(r_busy), 32'd45);
        check("t2b_done", 32'(r_done), 32'd1);

        // Test 3
        run_mult(8'hAB, 8'h00);
        check("t3_product", 32'(r_prod), 32'h0000);
        check("t3_busy", 32'(r_busy), 32'd44);
        check("t3_add_words", 32'(r_add), 32'd0);
        check("t3_done", 32'(r_done), 32'd1);

        // Test 4: Start held 60 cycles, operands changed mid-run
        A = 8'd3; B = 8'd5; Start = 1'b1;
        done_n = 0; rises = 0; prev_busy = 1'b0; r_prod = 16'hxxxx;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            if (c == 10) begin A = 8'd7; B = 8'd9; end
            if (Busy && !prev_busy) rises++;
            prev_busy = Busy;
            if (Done) begin done_n++; r_prod = Product; end
        end
        Start = 1'b0;
        check("t4_done_count", 32'(done_n), 32'd1);
        check("t4_product", 32'(r_prod), 32'd15);
        check("t4_run_starts", 32'(rises), 32'd2);
        prod2 = 16'hxxxx; done_n = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge Clock);
            if (Done) begin done_n++; prod2 = Product; end
        end
        check("t4_second_done", 32'(done_n), 32'd1);
        check("t4_second_product", 32'(prod2), 32'd63);

        // Test 5: async reset mid-run
        A = 8'h1F; B = 8'hE3; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (19) @(negedge Clock);
        check("t5_busy_before_reset", 32'(Busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("t5_busy_in_reset", 32'(Busy), 32'd0);
        check("t5_product_in_reset", 32'(Product), 32'd0);
        check("t5_instr_in_reset", 32'(Instruction), 32'(W_IDLE));
        @(negedge Clock);
        Reset = 1'b0;
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clock);
            if (Done) done_n++;
            if (Busy) busy_n++;
        end
        check("t5_no_done", 32'(done_n), 32'd0);
        check("t5_idle_after", 32'(busy_n), 32'd0);
        check("t5_product_zero", 32'(Product), 32'd0);
        run_mult(8'h1F, 8'hE3);
        check("t5_rerun_product", 32'(r_prod), 32'h1B7D);
        check("t5_rerun_busy", 32'(r_busy), 32'd49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
